pcm_sample_fifo: RTL

Sample buffer directly upstream of the audio DAC. Accepts unsigned PCM samples from the CPU/bus side via a valid/ready handshake and stores them in a circular FIFO. Releases exactly one sample per rising edge of sample_clock onto the pcm output that drives the DAC. Provides level, low-water and sticky underrun status so software can refill the buffer before it drains.

---
 rtl/pcm_sample_fifo_if.sv | 11 +
 rtl/pcm_sample_fifo.sv | 101 ++++++++++
 2 files changed

// File: rtl/pcm_sample_fifo_if.sv
// rtl/pcm_sample_fifo_if.sv - sample push handshake between bus side and the DAC buffer
interface pcm_sample_fifo_if #(
  parameter int BITDEPTH = 12
);
  logic [BITDEPTH-1:0] in_data;
  logic                in_valid;
  logic                in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/pcm_sample_fifo.sv
// rtl/pcm_sample_fifo.sv - circular PCM sample buffer releasing one sample per sample_clock rising edge
module pcm_sample_fifo #(
  parameter int BITDEPTH   = 12,
  parameter int DEPTH_LOG2 = 6,
  parameter int LOW_WATER  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_clock,
  input  logic                  flush,
  input  logic                  clr_underrun,
  pcm_sample_fifo_if.slave      in_if,
  output logic [BITDEPTH-1:0]   pcm,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  low_water,
  output logic                  underrun
);

  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [LVL_W-1:0]    DEPTH_L     = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]    LOW_WATER_L = LVL_W'(LOW_WATER);
  localparam logic [BITDEPTH-1:0] MIDSCALE    = {1'b1, {(BITDEPTH-1){1'b0}}};

  logic [BITDEPTH-1:0]   mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [BITDEPTH-1:0]   pcm_q, pcm_d;
  logic                  underrun_q, underrun_d;
  logic                  low_water_q, low_water_d;
  logic                  sc_prev_q;

  logic tick, empty, full, ready_w, push, pop;

  assign tick    = sample_clock & ~sc_prev_q;
  assign empty   = (level_q == '0);
  assign full    = (level_q == DEPTH_L);
  // Ready depends only on current level, so a full FIFO refuses a push even while popping.
  assign ready_w = rst & ~flush & ~full;
  assign push    = in_if.in_valid & ready_w;
  assign pop     = tick & ~empty;

  assign in_if.in_ready = ready_w;
  assign pcm       = pcm_q;
  assign level     = level_q;
  assign low_water = low_water_q;
  assign underrun  = underrun_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    pcm_d      = pcm_q;
    underrun_d = underrun_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      pcm_d      = MIDSCALE;
      underrun_d = underrun_q & ~clr_underrun;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        pcm_d    = mem[rd_ptr_q];
      end
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
      // An empty tick holds pcm (no click) and a same-cycle clear loses to it.
      if (tick && empty)     underrun_d = 1'b1;
      else if (clr_underrun) underrun_d = 1'b0;
    end
    low_water_d = (level_d < LOW_WATER_L);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pcm_q       <= MIDSCALE;
      underrun_q  <= 1'b0;
      low_water_q <= 1'b1;
      sc_prev_q   <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pcm_q       <= pcm_d;
      underrun_q  <= underrun_d;
      low_water_q <= low_water_d;
      sc_prev_q   <= sample_clock;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_if.in_data;
  end

endmodule
